alu_exec_unit: RTL and testbench

//  Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder plus two XLEN operands.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shift_iter.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 154 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and FSM state type for the ALU decoder and execute unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1111;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: shifts a latched operand by up to SHIFT_STEP bits per cycle.
// done pulses on the cycle of the last step; result then carries the final value.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [XLEN-1:0]    src,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  logic [XLEN-1:0]    sh_q, sh_d, sh_next;
  logic [SHAMT_W-1:0] rem_q, rem_d, step;
  logic [3:0]         op_q, op_d;
  logic               busy_q, busy_d;

  always_comb begin
    step = (rem_q < STEP) ? rem_q : STEP;
    case (op_q)
      ALU_SLL: sh_next = sh_q << step;
      // sign bit stays in place, so each step refills with the original bit XLEN-1
      ALU_SRA: sh_next = $unsigned($signed(sh_q) >>> step);
      default: sh_next = sh_q >> step;
    endcase
  end

  assign done   = busy_q & (rem_q <= STEP);
  assign result = sh_next;

  always_comb begin
    sh_d   = sh_q;
    rem_d  = rem_q;
    op_d   = op_q;
    busy_d = busy_q;
    if (flush) begin
      busy_d = 1'b0;
      rem_d  = '0;
    end else if (start) begin
      sh_d   = src;
      rem_d  = shamt;
      op_d   = op;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d   = sh_next;
      rem_d  = rem_q - step;
      busy_d = ~done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rem_q  <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a single registered result slot.
// ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter instead of alu_shift_iter.
//   state    | meaning
//   ST_IDLE  | no op in flight, no result held
//   ST_SHIFT | iterative shift in progress
//   ST_DONE  | result held, out_valid=1 until consumed
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e         state_q, state_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    comb_shift;
  logic               alu_legal;
  logic               accept;
  logic               go_shift;
  logic               sh_done;
  logic [XLEN-1:0]    sh_result;

  assign shamt     = src_b[SHAMT_W-1:0];
  assign out_valid = (state_q == ST_DONE);
  // a held result that is being consumed frees the slot for a back-to-back accept
  assign in_ready  = (state_q != ST_SHIFT) & (~out_valid | out_ready) & ~flush;
  assign accept    = in_valid & in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift  = 1'b0;
  assign sh_done   = 1'b0;
  assign sh_result = '0;

  always_comb begin
    case (alu_ctrl)
      ALU_SLL: comb_shift = src_a << shamt;
      ALU_SRA: comb_shift = $unsigned($signed(src_a) >>> shamt);
      default: comb_shift = src_a >> shamt;
    endcase
  end
`else
  // only shamt==0 shifts complete in the accept cycle, and those return src_a
  assign comb_shift = src_a;
  assign go_shift   = is_shift_op(alu_ctrl) && (shamt != '0);

  alu_shift_iter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .SHAMT_W    (SHAMT_W)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (accept & go_shift),
    .op     (alu_ctrl),
    .src    (src_a),
    .shamt  (shamt),
    .done   (sh_done),
    .result (sh_result)
  );
`endif

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (alu_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = comb_shift;
      default:  alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
          if (accept) begin
            if (go_shift) begin
              state_d   = ST_SHIFT;
              illegal_d = 1'b0;
            end else begin
              state_d   = ST_DONE;
              result_d  = alu_res;
              zero_d    = (alu_res == '0);
              illegal_d = ~alu_legal;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            state_d   = ST_DONE;
            result_d  = sh_result;
            zero_d    = (sh_result == '0);
            illegal_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: behavioural scoreboard plus directed literal vectors.
module tb_alu_exec_unit;

  localparam int XLEN = 32;
  localparam int STEP = 1;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] src_a, src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il);
    il = 1'b0;
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      4'b1000: r = a << b[4:0];
      4'b1111: r = a >> b[4:0];
      4'b1001: r = $unsigned($signed(a) >>> b[4:0]);
      default: begin r = 32'd0; il = 1'b1; end
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (FAST || !(c == 4'b1000 || c == 4'b1111 || c == 4'b1001) || sh == 0) return 1;
    return 1 + (sh + STEP - 1) / STEP;
  endfunction

  bit          m_valid;
  int          m_wait;
  logic [31:0] m_res, p_res;
  logic        m_ill, p_ill;

  function automatic bit exp_ready();
    return (m_wait == 0) && (!m_valid || out_ready) && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit          acc;
    logic [31:0] r;
    logic        il;
    int          l;
    if (!rst_n) begin
      m_valid = 1'b0; m_wait = 0; m_res = '0; m_ill = 1'b0;
    end else begin
      acc = in_valid && exp_ready();
      if (flush) begin
        m_valid = 1'b0;
        m_wait  = 0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin m_valid = 1'b1; m_res = p_res; m_ill = p_ill; end
        end
        if (acc) begin
          ref_alu(alu_ctrl, src_a, src_b, r, il);
          l = lat_of(alu_ctrl, src_b);
          if (l == 1) begin
            m_valid = 1'b1; m_res = r; m_ill = il;
          end else begin
            m_wait = l - 1; p_res = r; p_ill = il;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check("result", result, m_res);
        check("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
        check("illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_ready()) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = ~c; src_a = ~a; src_b = ~b;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input bit exp_il);
    int lat;
    send(c, a, b);
    wait_valid(lat);
    check({nm, "_lat"}, lat, lat_of(c, b));
    check({nm, "_res"}, result, exp_r);
    check({nm, "_zero"}, {31'd0, zero}, {31'd0, (exp_r == 32'd0)});
    check({nm, "_ill"}, {31'd0, illegal_op}, {31'd0, exp_il});
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // back-to-back add then sub
    send(4'b0000, 32'h7FFF_FFFF, 32'h1);
    check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_add_res", result, 32'h8000_0000);
    send(4'b0001, 32'd5, 32'd5);
    check("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_sub_res", result, 32'd0);
    check("b2b_sub_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;

    run_vec("slt",   4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    run_vec("sltu",  4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    send(4'b1001, 32'h8000_0000, 32'd31);
    wait_valid(lat);
    check("sra31_lat", lat, FAST ? 32'd1 : 32'd32);
    check("sra31_res", result, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    run_vec("srl31", 4'b1111, 32'h8000_0000, 32'd31, 32'h1, 1'b0);
    run_vec("sll0",  4'b1000, 32'h1, 32'd0, 32'h1, 1'b0);
    run_vec("and",   4'b0010, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    run_vec("or",    4'b0011, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0);
    run_vec("subneg",4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
    run_vec("addwrap",4'b0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    run_vec("sra4",  4'b1001, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0);
    run_vec("srl4",  4'b1111, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0);
    run_vec("sllhi", 4'b1000, 32'h3, 32'hFFFF_FFE5, 32'h60, 1'b0);
    run_vec("ill6",  4'b0110, 32'h1234, 32'h5678, 32'h0, 1'b1);
    run_vec("illA",  4'b1010, 32'h1, 32'h1, 32'h0, 1'b1);

    // backpressure
    out_ready = 1'b0;
    send(4'b0100, 32'hF0F0, 32'h0FF0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_res", result, 32'hFF00);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // flush mid-shift
    send(4'b1000, 32'h1, 32'd20);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 30; i++) begin
      check("flush_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send(4'b0000, 32'd2, 32'd3);
    check("post_flush_valid", {31'd0, out_valid}, 32'd1);
    check("post_flush_res", result, 32'd5);
    @(posedge clk); #1;

    // reset mid-shift
    send(4'b1000, 32'h1, 32'd20);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_result", result, 32'd0);
    check("rstmid_zero", {31'd0, zero}, 32'd0);
    check("rstmid_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      check("rstmid_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    run_vec("post_rst_add", 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
